// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCode values, SR/Cause field positions.
// Pure declarations, no logic.
// Imported by cp0_exc_unit and cp0_timer.
package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // ExcCode encodings (Cause[6:2])
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions; only IM, EXL and IE are implemented
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match raises a sticky pending flag.
// Latency: all state visible one edge after the cause; pending sets the edge after Count==Compare.
// No backpressure; mtc0 strobes are qualified by the parent.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_pending
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_pending;
  logic        w_match;

  // Compare == 0 is treated as "timer disarmed"
  assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

  // Count increments every cycle; a load replaces that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_count <= 32'd0;
    else if (i_count_we) r_count <= i_wdata;
    else                 r_count <= r_count + 32'd1;
  end

  // Compare only changes through mtc0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_compare <= 32'd0;
    else if (i_compare_we) r_compare <= i_wdata;
  end

  // Pending is sticky until software rewrites Compare; the clear wins over a same-cycle match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_pending <= 1'b0;
    else if (i_compare_we) r_pending <= 1'b0;
    else if (w_match)      r_pending <= 1'b1;
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_pending = r_pending;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId, Count/Compare, mfc0/mtc0, eret.
// Latency: exc_req and cp0_rdata are combinational; every register update lands one edge later.
// No backpressure; an exception taken in the same cycle as an mtc0 drops the write.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] macro_pc,
  input  logic        macro_bd,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        exc_req,
  output logic [31:0] handler_pc,
  output logic        timer_irq
);

  logic [31:0] r_sr;
  logic [5:0]  r_ip;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_int_req;
  logic        w_wr_ok;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_pending;
  logic [31:0] w_cause;

  // EXL doubles as the NORMAL/HANDLER state bit
  assign w_exl     = r_sr[SR_EXL];
  assign w_int_req = r_sr[SR_IE] & ~w_exl & (|(r_sr[SR_IM_HI:SR_IM_LO] & r_ip));
  assign exc_req   = ~w_exl & (w_int_req | exc_valid);
  // A taken exception squashes any mtc0 in the same cycle
  assign w_wr_ok   = cp0_we & ~exc_req;

  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_count_we   (w_wr_ok && (cp0_addr == CP0_COUNT)),
    .i_compare_we (w_wr_ok && (cp0_addr == CP0_COMPARE)),
    .i_wdata      (cp0_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_pending    (w_pending)
  );

  // SR: exception entry sets EXL; otherwise mtc0 then eret (eret clears EXL last)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 32'd0;
    end else if (exc_req) begin
      r_sr[SR_EXL] <= 1'b1;
    end else begin
      if (w_wr_ok && (cp0_addr == CP0_SR)) r_sr <= cp0_wdata & SR_WMASK;
      if (eret && w_exl)                   r_sr[SR_EXL] <= 1'b0;
    end
  end

  // IP is resampled every edge; the top line is shared with the timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ip <= 6'd0;
    else        r_ip <= {hw_int[5] | w_pending, hw_int[4:0]};
  end

  // BD and ExcCode are captured only when an exception is taken; interrupts win over exc_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
    end else if (exc_req) begin
      r_bd       <= macro_bd;
      r_exc_code <= w_int_req ? EXC_INT : exc_code;
    end
  end

  // EPC points at the branch when the victim sits in a delay slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_epc <= 32'd0;
    else if (exc_req)                             r_epc <= macro_bd ? (macro_pc - 32'd4) : macro_pc;
    else if (w_wr_ok && (cp0_addr == CP0_EPC))    r_epc <= cp0_wdata;
  end

  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};

  // mfc0 read mux; reflects register state only, never a same-cycle write
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_COUNT:   cp0_rdata = w_count;
      CP0_COMPARE: cp0_rdata = w_compare;
      CP0_SR:      cp0_rdata = r_sr;
      CP0_CAUSE:   cp0_rdata = w_cause;
      CP0_EPC:     cp0_rdata = r_epc;
      CP0_PRID:    cp0_rdata = PRID_VALUE;
      default:     cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out    = r_epc;
  assign handler_pc = HANDLER_ADDR;
  assign timer_irq  = w_pending;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are sampled before the next edge.
// Each test task performs its own comparisons.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] macro_pc = 32'd0;
  logic        macro_bd = 1'b0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [5:0]  hw_int = 6'd0;
  logic [4:0]  cp0_addr = 5'd0;
  logic        cp0_we = 1'b0;
  logic [31:0] cp0_wdata = 32'd0;
  logic        eret = 1'b0;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        exc_req;
  logic [31:0] handler_pc;
  logic        timer_irq;

  int total = 0;
  int bad = 0;

  cp0_exc_unit dut (
    .clk(clk), .rst_n(rst_n), .macro_pc(macro_pc), .macro_bd(macro_bd),
    .exc_valid(exc_valid), .exc_code(exc_code), .hw_int(hw_int),
    .cp0_addr(cp0_addr), .cp0_we(cp0_we), .cp0_wdata(cp0_wdata), .eret(eret),
    .cp0_rdata(cp0_rdata), .epc_out(epc_out), .exc_req(exc_req),
    .handler_pc(handler_pc), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_addr = a; cp0_wdata = d; cp0_we = 1'b1;
    step();
    cp0_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    #2;
    total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL rst_exc_req got=%b exp=0", exc_req); end
    total++; if (epc_out !== 32'd0) begin bad++; $display("FAIL rst_epc_out got=%h exp=0", epc_out); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL rst_timer_irq got=%b exp=0", timer_irq); end
    total++; if (handler_pc !== 32'h0000_4180) begin bad++; $display("FAIL handler_pc got=%h exp=00004180", handler_pc); end
    rd(5'd0, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_rd_addr0 got=%h exp=0", d); end
    rd(5'd12, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_sr got=%h exp=0", d); end
    rd(5'd9, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_count got=%h exp=0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    macro_pc = 32'h0000_3010; macro_bd = 1'b0; hw_int = 6'b000001;
    step();
    mtc0(5'd12, 32'h0000_FC01);
    total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL int_exc_req got=%b exp=1", exc_req); end
    step();
    rd(5'd13, d);
    total++; if (d !== 32'h0000_0400) begin bad++; $display("FAIL int_cause got=%h exp=00000400", d); end
    rd(5'd12, d);
    total++; if (d !== 32'h0000_FC03) begin bad++; $display("FAIL int_sr got=%h exp=0000fc03", d); end
    total++; if (epc_out !== 32'h0000_3010) begin bad++; $display("FAIL int_epc got=%h exp=00003010", epc_out); end
    total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL int_nested_req got=%b exp=0", exc_req); end
    hw_int = 6'd0; eret = 1'b1;
    step();
    eret = 1'b0;
    rd(5'd12, d);
    total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL int_eret_sr got=%h exp=0000fc01", d); end
  endtask

  task automatic test_exception_bd();
    logic [31:0] d;
    exc_valid = 1'b1; exc_code = 5'd12; macro_pc = 32'h0000_3024; macro_bd = 1'b1;
    #1;
    total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL bd_exc_req got=%b exp=1", exc_req); end
    step();
    exc_valid = 1'b0; macro_bd = 1'b0;
    total++; if (epc_out !== 32'h0000_3020) begin bad++; $display("FAIL bd_epc got=%h exp=00003020", epc_out); end
    rd(5'd13, d);
    total++; if (d !== 32'h8000_0030) begin bad++; $display("FAIL bd_cause got=%h exp=80000030", d); end
  endtask

  task automatic test_handler_eret();
    logic [31:0] d;
    exc_valid = 1'b1; exc_code = 5'd5; macro_pc = 32'h0000_5000;
    #1;
    total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL hnd_exc_req got=%b exp=0", exc_req); end
    step();
    exc_valid = 1'b0;
    total++; if (epc_out !== 32'h0000_3020) begin bad++; $display("FAIL hnd_epc got=%h exp=00003020", epc_out); end
    rd(5'd13, d);
    total++; if (d !== 32'h8000_0030) begin bad++; $display("FAIL hnd_cause got=%h exp=80000030", d); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(5'd12, d);
    total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL hnd_eret_sr got=%h exp=0000fc01", d); end
    total++; if (epc_out !== 32'h0000_3020) begin bad++; $display("FAIL hnd_eret_epc got=%h exp=00003020", epc_out); end
    // eret in NORMAL together with an EPC write
    cp0_addr = 5'd14; cp0_wdata = 32'h1234_5678; cp0_we = 1'b1; eret = 1'b1;
    #1;
    total++; if (epc_out !== 32'h0000_3020) begin bad++; $display("FAIL epcwr_same_cycle got=%h exp=00003020", epc_out); end
    step();
    cp0_we = 1'b0; eret = 1'b0;
    total++; if (epc_out !== 32'h1234_5678) begin bad++; $display("FAIL epcwr_after got=%h exp=12345678", epc_out); end
    rd(5'd12, d);
    total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL eret_normal_sr got=%h exp=0000fc01", d); end
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL count_load got=%h exp=ffffffff", d); end
    step();
    rd(5'd9, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h exp=0", d); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, d);
    total++; if (d !== 32'h8000_0030) begin bad++; $display("FAIL cause_ro got=%h exp=80000030", d); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 5; i++) step();
    rd(5'd9, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL tmr_count got=%h exp=5", d); end
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tmr_early got=%b exp=0", timer_irq); end
    step();
    total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL tmr_rise got=%b exp=1", timer_irq); end
    total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL tmr_ip_lag got=%b exp=0", exc_req); end
    step();
    exc_valid = 1'b1; exc_code = 5'd12; macro_pc = 32'h0000_6000; macro_bd = 1'b0;
    #1;
    total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL tmr_exc_req got=%b exp=1", exc_req); end
    step();
    exc_valid = 1'b0;
    rd(5'd13, d);
    total++; if (d !== 32'h0000_8000) begin bad++; $display("FAIL tmr_cause got=%h exp=00008000", d); end
    total++; if (epc_out !== 32'h0000_6000) begin bad++; $display("FAIL tmr_epc got=%h exp=00006000", epc_out); end
    mtc0(5'd11, 32'd0);
    total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tmr_clear got=%b exp=0", timer_irq); end
    step();
    rd(5'd13, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL tmr_ip_clear got=%h exp=0", d); end
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic test_exc_vs_mtc0();
    logic [31:0] d;
    exc_valid = 1'b1; exc_code = 5'd4; macro_pc = 32'h0000_7000; macro_bd = 1'b0;
    cp0_addr = 5'd12; cp0_wdata = 32'd0; cp0_we = 1'b1;
    #1;
    total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL race_exc_req got=%b exp=1", exc_req); end
    step();
    exc_valid = 1'b0; cp0_we = 1'b0;
    rd(5'd12, d);
    total++; if (d !== 32'h0000_8003) begin bad++; $display("FAIL race_sr got=%h exp=00008003", d); end
    rd(5'd13, d);
    total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL race_cause got=%h exp=00000010", d); end
    total++; if (epc_out !== 32'h0000_7000) begin bad++; $display("FAIL race_epc got=%h exp=00007000", epc_out); end
  endtask

  task automatic test_reset_mid_handler();
    logic [31:0] d;
    rst_n = 1'b0;
    #1;
    total++; if (epc_out !== 32'd0) begin bad++; $display("FAIL mrst_epc got=%h exp=0", epc_out); end
    total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL mrst_exc_req got=%b exp=0", exc_req); end
    rd(5'd12, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mrst_sr got=%h exp=0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd(5'd15, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL prid got=%h exp=00000001", d); end
    rd(5'd13, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mrst_cause got=%h exp=0", d); end
    mtc0(5'd15, 32'hDEAD_BEEF);
    rd(5'd15, d);
    total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL prid_ro got=%h exp=00000001", d); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_handler_eret();
    test_count_wrap();
    test_timer();
    test_exc_vs_mtc0();
    test_reset_mid_handler();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
